mac_unit_acc: RTL

- Parametrised successor to the systolic-array MAC cell.
- Keeps the double-buffered weight (preload/load) and the 3-stage data pipeline.
- Adds configurable operand and accumulator widths, per-sample valid tracking, and a per-sample mode:
  - weight-stationary pass-through (product + last_sum)
  - output-stationary local accumulation with clear
- Adds optional saturation and a sticky overflow flag.
- Sits inside the systolic array as the per-cell compute element.

---
 rtl/mac_unit_acc.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mac_unit_acc.sv
// Per-cell MAC for the systolic array: double-buffered weight, 3-stage data pipeline,
// per-sample WS pass-through / OS accumulate, optional saturation with a sticky overflow flag.
module mac_unit_acc #(
  parameter int DATA_WIDTH     = 9,
  parameter int ACC_WIDTH      = 32,
  parameter int LAST_SUM_WIDTH = 0,
  parameter bit SATURATE       = 1'b1
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     enable,
  input  logic signed [DATA_WIDTH-1:0]                             weight_in,
  input  logic                                                     preload_weight,
  input  logic                                                     load_weight,
  input  logic signed [DATA_WIDTH-1:0]                             data_in,
  input  logic                                                     data_valid,
  input  logic                                                     mode,
  input  logic                                                     acc_clear,
  input  logic signed [((LAST_SUM_WIDTH > 0) ? LAST_SUM_WIDTH : 1)-1:0] last_sum,
  output logic signed [ACC_WIDTH-1:0]                              partial_sum,
  output logic                                                     partial_sum_valid,
  output logic                                                     overflow
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  if (ACC_WIDTH < 2 * DATA_WIDTH || LAST_SUM_WIDTH > ACC_WIDTH) begin : g_bad_params
    $error("mac_unit_acc: illegal width parameters");
  end

  // Handshake: data_valid marks a sample on data_in (no backpressure; enable=0 stalls the
  // whole pipeline). partial_sum_valid pulses for exactly one enabled cycle per sample.

  logic signed [DATA_WIDTH-1:0] preweight;
  logic signed [DATA_WIDTH-1:0] weight;

  logic signed [DATA_WIDTH-1:0] s1_data;
  logic                         s1_valid;
  logic                         s1_mode;
  logic                         s1_clear;

  logic signed [PW-1:0]         s2_prod;
  logic                         s2_valid;
  logic                         s2_mode;
  logic                         s2_clear;

  logic signed [ACC_WIDTH-1:0]  acc;

  logic signed [SW-1:0]         prod_ext;
  logic signed [SW-1:0]         base_ext;
  logic signed [SW-1:0]         chain_ext;
  logic signed [SW-1:0]         sum;
  logic                         sum_ovf;
  logic signed [ACC_WIDTH-1:0]  result;

  if (LAST_SUM_WIDTH > 0) begin : g_chain
    assign chain_ext = SW'(last_sum);
  end else begin : g_no_chain
    logic unused_last_sum;
    assign unused_last_sum = ^last_sum;
    assign chain_ext       = '0;
  end

  // Weight buffer ignores enable; a simultaneous preload+load moves the old preweight.
  always_ff @(posedge clk) begin
    if (rst) begin
      preweight <= '0;
      weight    <= '0;
    end else begin
      if (load_weight)    weight    <= preweight;
      if (preload_weight) preweight <= weight_in;
    end
  end

  // The sum carries one guard bit so overflow is a disagreement of the top two bits.
  always_comb begin
    prod_ext = SW'(s2_prod);
    base_ext = s2_clear ? '0 : SW'(acc);
    sum      = s2_mode ? (base_ext + prod_ext) : (prod_ext + chain_ext);
    sum_ovf  = sum[SW-1] != sum[SW-2];
    result   = sum[ACC_WIDTH-1:0];
    if (sum_ovf && SATURATE) result = sum[SW-1] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data           <= '0;
      s1_valid          <= 1'b0;
      s1_mode           <= 1'b0;
      s1_clear          <= 1'b0;
      s2_prod           <= '0;
      s2_valid          <= 1'b0;
      s2_mode           <= 1'b0;
      s2_clear          <= 1'b0;
      acc               <= '0;
      partial_sum       <= '0;
      partial_sum_valid <= 1'b0;
      overflow          <= 1'b0;
    end else if (enable) begin
      s1_data           <= data_in;
      s1_valid          <= data_valid;
      s1_mode           <= mode;
      s1_clear          <= acc_clear;
      s2_prod           <= PW'(s1_data) * PW'(weight);
      s2_valid          <= s1_valid;
      s2_mode           <= s1_mode;
      s2_clear          <= s1_clear;
      partial_sum_valid <= s2_valid;
      if (s2_valid) begin
        partial_sum <= result;
        if (s2_mode) acc <= result;
      end else if (s2_clear) begin
        acc         <= '0;
        partial_sum <= '0;
      end
      // A fresh overflow wins over the clear carried by the same sample.
      overflow <= (s2_valid & sum_ovf) | (overflow & ~s2_clear);
    end else begin
      partial_sum_valid <= 1'b0;
    end
  end

endmodule
